aes_mix_columns_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_mix_column.sv | 41 ++++
 rtl/aes_mix_columns_iter.sv | 130 +++++++++++++
 tb/tb_aes_mix_columns_iter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : aes_pkg                                                    |
// | Description : Shared AES datapath definitions: GF(2^8) multiply-by-      |
// |               constant helpers (modulo x^8+x^4+x^3+x+1), MixColumns mode |
// |               encodings and the iterative MixColumns FSM state type.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package aes_pkg;

  // Per-transaction transform selection.
  localparam logic AES_MODE_FWD = 1'b0;
  localparam logic AES_MODE_INV = 1'b1;

  // Iterative MixColumns control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_t;

  // Multiply by x, reducing by 0x11B when the top bit falls out.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // The inverse coefficients are built from x^3, x^2 and x terms.
  function automatic logic [7:0] gm9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_mix_column.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aes_mix_column                                             |
// | Description : Combinational single-column MixColumns / InvMixColumns.    |
// |   col_in  [31:0] in  : column, byte 0 in [31:24]                         |
// |   inv            in  : 0 = forward {02,03,01,01}, 1 = inverse            |
// |                        {0e,0b,0d,09}                                      |
// |   col_out [31:0] out : transformed column, same byte order               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module aes_mix_column (
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);
  import aes_pkg::*;

  logic [7:0] b0, b1, b2, b3;
  logic [31:0] fwd_col, inv_col;

  assign b0 = col_in[31:24];
  assign b1 = col_in[23:16];
  assign b2 = col_in[15:8];
  assign b3 = col_in[7:0];

  always_comb begin
    fwd_col[31:24] = gm2(b0) ^ gm3(b1) ^ b2      ^ b3;
    fwd_col[23:16] = b0      ^ gm2(b1) ^ gm3(b2) ^ b3;
    fwd_col[15:8]  = b0      ^ b1      ^ gm2(b2) ^ gm3(b3);
    fwd_col[7:0]   = gm3(b0) ^ b1      ^ b2      ^ gm2(b3);

    inv_col[31:24] = gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3);
    inv_col[23:16] = gm9(b0)  ^ gm14(b1) ^ gm11(b2) ^ gm13(b3);
    inv_col[15:8]  = gm13(b0) ^ gm9(b1)  ^ gm14(b2) ^ gm11(b3);
    inv_col[7:0]   = gm11(b0) ^ gm13(b1) ^ gm9(b2)  ^ gm14(b3);
  end

  assign col_out = (inv == AES_MODE_INV) ? inv_col : fwd_col;

endmodule
`default_nettype wire

// File: rtl/aes_mix_columns_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aes_mix_columns_iter                                       |
// | Description : Iterative handshaked MixColumns / InvMixColumns engine.    |
// |               Transforms COLS_PER_CYCLE columns per clock in place in a  |
// |               working register, then presents the state until taken.    |
// |   clk, rst_n           : clock, asynchronous active-low reset            |
// |   in_valid/in_ready    : input handshake (in_ready is combinational      |
// |                          from out_ready while a result is held)          |
// |   in_data[127:0]       : state, column 0 = [127:96], byte 0 = MSB        |
// |   in_inv               : 0 = MixColumns, 1 = InvMixColumns               |
// |   out_valid/out_ready  : output handshake                                |
// |   out_data[127:0]      : transformed state (registered)                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module aes_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  import aes_pkg::*;

  localparam int NBEATS = 4 / COLS_PER_CYCLE;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_t        state;
  logic [IDX_W-1:0] col_idx;
  logic             mode;
  // Packed [0:3] so that work[0] is column 0 in bits [127:96].
  logic [0:3][31:0] work;
  logic [0:3][31:0] work_next;
  logic             accept;

  logic [1:0]  lane_sel [COLS_PER_CYCLE];
  logic [31:0] lane_in  [COLS_PER_CYCLE];
  logic [31:0] lane_out [COLS_PER_CYCLE];

  // Lane j handles column col_idx*C + j this beat.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
    assign lane_sel[j] = 2'(int'(col_idx) * COLS_PER_CYCLE + j);
    assign lane_in[j]  = work[lane_sel[j]];

    aes_mix_column u_col (
      .col_in  (lane_in[j]),
      .inv     (mode),
      .col_out (lane_out[j])
    );
  end

  always_comb begin
    work_next = work;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      work_next[lane_sel[j]] = lane_out[j];
    end
  end

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      col_idx   <= '0;
      mode      <= AES_MODE_FWD;
      work      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            work    <= in_data;
            mode    <= in_inv;
            col_idx <= '0;
            state   <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          work <= work_next;
          if (col_idx == LAST_IDX) begin
            // out_data is loaded only here so it never shows a partial state.
            out_data  <= work_next;
            out_valid <= 1'b1;
            col_idx   <= '0;
            state     <= ST_DONE;
          end else begin
            col_idx <= col_idx + 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              // Output handshake and new accept share this edge.
              work    <= in_data;
              mode    <= in_inv;
              col_idx <= '0;
              state   <= ST_BUSY;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          col_idx   <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_mix_columns_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_aes_mix_columns_iter                                    |
// | Description : Directed self-checking bench for aes_mix_columns_iter.     |
// |               Instance 0: C=1, instance 1: C=2, instance 2: C=4.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_aes_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         in_inv    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int C = (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    aes_mix_columns_iter #(.COLS_PER_CYCLE(C)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .in_data   (in_data[i]),
      .in_inv    (in_inv[i]),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out_data  (out_data[i])
    );
  end

  function automatic int nbeats(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
  endfunction

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix: element (row, c) = coef[(c - row) mod 4].
  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   b    [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int col = 0; col < 4; col++) begin
      for (int c = 0; c < 4; c++) b[c] = s[127 - 32*col - 8*c -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int c = 0; c < 4; c++) acc = acc ^ gmul(coef[(c - row) & 3], b[c]);
        r[127 - 32*col - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one block; caller ensures in_ready is high.
  task automatic send(input int k, input logic [127:0] d, input logic inv);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_inv[k]   = inv;
    step();
    in_valid[k] = 1'b0;
    in_data[k]  = 128'hdeadbeef_cafef00d_0badc0de_55aa55aa;
    in_inv[k]   = ~inv;
  endtask

  // Edges from the accept edge until out_valid is seen (bounded).
  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (out_valid[k] !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_inv[k] = 1'b0; out_ready[k] = 1'b1;
    end
    step();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_valid[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid[k]);
      end
      n_cmp++;
      if (out_data[k] !== 128'h0) begin
        n_fail++; $display("FAIL reset_out_data[%0d]: got %h expected 0", k, out_data[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (in_ready[k] !== 1'b1) begin
        n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, in_ready[k]);
      end
    end
  endtask

  task automatic test_forward_c1();
    int lat;
    out_ready[0] = 1'b1;
    send(0, 128'hdb135345_f20a225c_01010101_2d26314c, 1'b0);
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL fwd_c1_latency: got %0d expected 4", lat);
    end
    n_cmp++;
    if (out_data[0] !== 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8) begin
      n_fail++; $display("FAIL fwd_c1_data: got %h expected 8e4da1bc9fdc589d010101014d7ebdf8", out_data[0]);
    end
    n_cmp++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL fwd_c1_done_in_ready: got %b expected 1", in_ready[0]);
    end
    step();
    n_cmp++;
    if (out_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL fwd_c1_valid_drop: got %b expected 0", out_valid[0]);
    end
  endtask

  task automatic test_inverse_c4();
    int lat;
    out_ready[2] = 1'b1;
    send(2, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1);
    wait_out(2, lat);
    n_cmp++;
    if (lat !== 1) begin
      n_fail++; $display("FAIL inv_c4_latency: got %0d expected 1", lat);
    end
    n_cmp++;
    if (out_data[2] !== 128'hdb135345_f20a225c_01010101_2d26314c) begin
      n_fail++; $display("FAIL inv_c4_data: got %h expected db135345f20a225c010101012d26314c", out_data[2]);
    end
    step();
  endtask

  task automatic test_fixed_c2();
    int lat;
    out_ready[1] = 1'b1;
    send(1, 128'hc6c6c6c6_d4d4d4d5_01010101_c6c6c6c6, 1'b0);
    wait_out(1, lat);
    n_cmp++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL fixed_c2_latency: got %0d expected 2", lat);
    end
    n_cmp++;
    if (out_data[1] !== 128'hc6c6c6c6_d5d5d7d6_01010101_c6c6c6c6) begin
      n_fail++; $display("FAIL fixed_c2_data: got %h expected c6c6c6c6d5d5d7d601010101c6c6c6c6", out_data[1]);
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] x, y;
    x = 128'h00112233_44556677_8899aabb_ccddeeff;
    y = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    out_ready[0] = 1'b0;
    send(0, x, 1'b0);
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL bp_latency: got %0d expected 4", lat);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 128'h13579bdf_2468ace0_fedcba98_76543210 ^ 128'(i);
      in_inv[0]   = 1'b1;
      n_cmp++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== model(x, 1'b0) || in_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                 i, out_valid[0], in_ready[0], out_data[0], model(x, 1'b0));
      end
      step();
    end
    in_data[0]   = y;
    in_inv[0]    = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    n_cmp++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready[0]);
    end
    step();
    in_valid[0] = 1'b0;
    n_cmp++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL bp_same_edge_accept: got valid=%b ready=%b expected valid=0 ready=0",
                         out_valid[0], in_ready[0]);
    end
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 4 || out_data[0] !== model(y, 1'b1)) begin
      n_fail++; $display("FAIL bp_next_block: got lat=%0d data=%h expected lat=4 data=%h",
                         lat, out_data[0], model(y, 1'b1));
    end
    step();
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    logic [127:0] a, b;
    a = 128'hffeeddcc_bbaa9988_77665544_33221100;
    b = 128'ha5a5a5a5_5a5a5a5a_3c3c3c3c_c3c3c3c3;
    out_ready[0] = 1'b1;
    send(0, a, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_data[0] !== 128'h0) begin
      n_fail++; $display("FAIL rst_mid_busy: got valid=%b ready=%b data=%h expected valid=0 ready=1 data=0",
                         out_valid[0], in_ready[0], out_data[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(0, b, 1'b1);
    wait_out(0, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL rst_next_latency: got %0d expected 4", lat);
    end
    n_cmp++;
    if (out_data[0] !== model(b, 1'b1)) begin
      n_fail++; $display("FAIL rst_next_data: got %h expected %h", out_data[0], model(b, 1'b1));
    end
    step();
  endtask

  // Even transactions: random forward. Odd: inverse of the previous result,
  // which must give back the previous input exactly.
  task automatic test_back_to_back(input int k);
    logic [127:0] exp_q [$];
    logic [127:0] x, prev, expd;
    int sent, got, cyc;
    bit fire;
    sent = 0; got = 0; cyc = 0;
    out_ready[k] = 1'b1;
    prev = {$urandom, $urandom, $urandom, $urandom};
    x = prev; expd = model(prev, 1'b0);
    in_data[k] = x; in_inv[k] = 1'b0; in_valid[k] = 1'b1;
    while (got < 8 && cyc < 200) begin
      if (out_valid[k] === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got unexpected %h expected no result", k, out_data[k]);
        end else begin
          if (out_data[k] !== exp_q[0]) begin
            n_fail++; $display("FAIL b2b_data[%0d] #%0d: got %h expected %h", k, got, out_data[k], exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        n_cmp++;
        if (in_ready[k] !== 1'b1) begin
          n_fail++; $display("FAIL b2b_zero_dead[%0d]: got in_ready=%b expected 1", k, in_ready[k]);
        end
        got++;
      end
      fire = (in_valid[k] === 1'b1) && (in_ready[k] === 1'b1);
      step();
      cyc++;
      if (fire) begin
        exp_q.push_back(expd);
        sent++;
        if (sent >= 8) begin
          in_valid[k] = 1'b0;
        end else if (sent % 2 == 1) begin
          x = model(prev, 1'b0); expd = prev;
          in_data[k] = x; in_inv[k] = 1'b1;
        end else begin
          prev = {$urandom, $urandom, $urandom, $urandom};
          x = prev; expd = model(prev, 1'b0);
          in_data[k] = x; in_inv[k] = 1'b0;
        end
      end
    end
    n_cmp++;
    if (got !== 8) begin
      n_fail++; $display("FAIL b2b_count[%0d]: got %0d results expected 8", k, got);
    end
    in_valid[k] = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_forward_c1();
    test_inverse_c4();
    test_fixed_c2();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
